// File: rtl/uart_verici_tamponlu_pkg.sv
// Shared UART transmit constants and FSM state encodings (CLK_HZ/BAUD_RATE sit with the integrator).
// Parity state PARITE is only reached when UART_PARITY_EN is defined.
package uart_verici_tamponlu_pkg;

    localparam int UART_VERI_BIT = 8;

    typedef enum logic [2:0] {
        BOSTA  = 3'd0,
        BASLA  = 3'd1,
        VERI   = 3'd2,
        PARITE = 3'd3,
        DUR    = 3'd4
    } durum_t;

endpackage

// File: rtl/verici_tampon.sv
// Circular byte FIFO with registered ready/occupancy.
// Latency: pushed byte visible at the head one edge later; ready drops on the edge that fills it.
module verici_tampon #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         yaz_gecerli,
    input  logic [W-1:0]                 yaz_veri,
    output logic                         hazir,
    input  logic                         oku,
    output logic [W-1:0]                 oku_veri,
    output logic                         bos,
    output logic [$clog2(DEPTH+1)-1:0]   doluluk
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] sayac, sayac_n;
    logic          hazir_q;
    logic          yaz_ok, oku_ok;

    assign yaz_ok = yaz_gecerli && hazir_q;
    assign oku_ok = oku && (sayac != '0);

    always_comb begin
        sayac_n = sayac;
        if (yaz_ok && !oku_ok)
            sayac_n = sayac + CW'(1);
        else if (!yaz_ok && oku_ok)
            sayac_n = sayac - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sayac   <= '0;
            hazir_q <= 1'b1;
        end else begin
            if (yaz_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (oku_ok)
                rd_ptr <= rd_ptr + AW'(1);
            sayac   <= sayac_n;
            hazir_q <= (sayac_n != CW'(DEPTH));
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (yaz_ok)
            mem[wr_ptr] <= yaz_veri;
    end

    assign oku_veri = mem[rd_ptr];
    assign bos      = (sayac == '0);
    assign doluluk  = sayac;
    assign hazir    = hazir_q;

endmodule

// File: rtl/uart_verici_tamponlu.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser, 8E1 when UART_PARITY_EN is defined.
// Latency: start bit begins one edge after acceptance; frames are 10 (11) bit times, back-to-back.
// Backpressure: hazir_o low while the FIFO is full; the source holds veri_i until accepted.
module uart_verici_tamponlu
    import uart_verici_tamponlu_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_W     = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [7:0]                        veri_i,
    input  logic                              veri_gecerli_i,
    output logic                              hazir_o,
    input  logic [BAUD_W-1:0]                 baud_div_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   doluluk_o,
    output logic                              mesgul_o,
    output logic                              tx_o
);

    durum_t       durum, durum_n;
    logic [BAUD_W-1:0] sayac, div_q;
    logic [7:0]   kaydirma, bas_veri;
    logic [2:0]   bit_idx, bit_idx_n;
    logic         tx_q, tx_n;
    logic         pop, yukle, kaydir, bos, wrap;
`ifdef UART_PARITY_EN
    logic         parite_q;
`endif

    verici_tampon #(.DEPTH(FIFO_DEPTH), .W(8)) u_tampon (
        .clk         (clk_i),
        .rst         (rst_i),
        .yaz_gecerli (veri_gecerli_i),
        .yaz_veri    (veri_i),
        .hazir       (hazir_o),
        .oku         (pop),
        .oku_veri    (bas_veri),
        .bos         (bos),
        .doluluk     (doluluk_o)
    );

    assign wrap = (sayac == div_q - BAUD_W'(1));

    always_comb begin
        durum_n   = durum;
        tx_n      = tx_q;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        yukle     = 1'b0;
        kaydir    = 1'b0;
        case (durum)
            BOSTA: begin
                tx_n = 1'b1;
                if (!bos) begin
                    pop     = 1'b1;
                    yukle   = 1'b1;
                    tx_n    = 1'b0;
                    durum_n = BASLA;
                end
            end
            BASLA: if (wrap) begin
                durum_n   = VERI;
                tx_n      = kaydirma[0];
                bit_idx_n = '0;
            end
            VERI: if (wrap) begin
                if (bit_idx == 3'(UART_VERI_BIT - 1)) begin
`ifdef UART_PARITY_EN
                    durum_n = PARITE;
                    tx_n    = parite_q;
`else
                    durum_n = DUR;
                    tx_n    = 1'b1;
`endif
                end else begin
                    bit_idx_n = bit_idx + 3'd1;
                    kaydir    = 1'b1;
                    tx_n      = kaydirma[1];
                end
            end
`ifdef UART_PARITY_EN
            PARITE: if (wrap) begin
                durum_n = DUR;
                tx_n    = 1'b1;
            end
`endif
            // Popping on the last stop-bit edge keeps frames gap-free.
            DUR: if (wrap) begin
                if (!bos) begin
                    pop     = 1'b1;
                    yukle   = 1'b1;
                    tx_n    = 1'b0;
                    durum_n = BASLA;
                end else begin
                    tx_n    = 1'b1;
                    durum_n = BOSTA;
                end
            end
            default: begin
                durum_n = BOSTA;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            durum <= BOSTA;
        else
            durum <= durum_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sayac    <= '0;
            div_q    <= '0;
            kaydirma <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            parite_q <= 1'b0;
`endif
        end else begin
            tx_q    <= tx_n;
            bit_idx <= bit_idx_n;
            if (yukle) begin
                // Divider is frozen per frame; zero behaves as one.
                kaydirma <= bas_veri;
                div_q    <= (baud_div_i == '0) ? BAUD_W'(1) : baud_div_i;
                sayac    <= '0;
`ifdef UART_PARITY_EN
                parite_q <= ^bas_veri;
`endif
            end else begin
                if (kaydir)
                    kaydirma <= kaydirma >> 1;
                if (durum != BOSTA)
                    sayac <= wrap ? '0 : sayac + BAUD_W'(1);
            end
        end
    end

    assign tx_o     = tx_q;
    assign mesgul_o = (durum != BOSTA) || !bos;

endmodule

// File: tb/tb_uart_verici_tamponlu.sv
// Directed bench for uart_verici_tamponlu (FIFO_DEPTH=4); define UART_PARITY_EN for the 8E1 steps.
module tb_uart_verici_tamponlu;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  veri = 8'h00;
    logic        gecerli = 1'b0;
    logic        hazir;
    logic [15:0] baud = 16'd4;
    logic [2:0]  doluluk;
    logic        mesgul;
    logic        tx;
    int          passed = 0;
    int          total = 0;

    uart_verici_tamponlu #(.FIFO_DEPTH(4), .BAUD_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .veri_i         (veri),
        .veri_gecerli_i (gecerli),
        .hazir_o        (hazir),
        .baud_div_i     (baud),
        .doluluk_o      (doluluk),
        .mesgul_o       (mesgul),
        .tx_o           (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
    endtask

    // Called just after a rising edge; returns #1 after the accepting edge.
    task automatic push(input logic [7:0] b, input string tag);
        logic acc;
        int   n;
        veri = b;
        gecerli = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = hazir;
            @(posedge clk);
            n++;
        end
        #1 gecerli = 1'b0;
        if (!acc) chk({tag, "_accept_timeout"}, 32'(acc), 32'd1);
    endtask

    // Next falling edge must be the first cycle of the start bit.
    task automatic frame(input logic [7:0] d, input int div, input string tag);
        logic [10:0] exp, obs;
        int glitch;
`ifdef UART_PARITY_EN
        exp = {1'b1, ^d, d, 1'b0};
`else
        exp = {1'b0, 1'b1, d, 1'b0};
`endif
        obs = '0;
        glitch = 0;
        for (int c = 0; c < NB * div; c++) begin
            @(negedge clk);
            if (c % div == div / 2) obs[c / div] = tx;
            if (tx !== exp[c / div]) glitch++;
        end
        chk({tag, "_bits"}, 32'(obs), 32'(exp));
        chk({tag, "_cycles"}, 32'(glitch), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_hazir", 32'(hazir), 32'd1);
        chk("rst_doluluk", 32'(doluluk), 32'd0);
        chk("rst_mesgul", 32'(mesgul), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single byte 0x55, div 4: line 0,1,0,1,0,1,0,1,0,1 over 40 cycles
        baud = 16'd4;
        push(8'h55, "single");
        @(negedge clk);
        chk("single_idle_tx", 32'(tx), 32'd1);
        chk("single_doluluk", 32'(doluluk), 32'd1);
        chk("single_mesgul", 32'(mesgul), 32'd1);
        frame(8'h55, 4, "single");
        @(negedge clk);
        chk("single_end_mesgul", 32'(mesgul), 32'd0);
        chk("single_end_tx", 32'(tx), 32'd1);

        // Divider 0 behaves as 1
        @(posedge clk); #1 baud = 16'd0;
        push(8'hA3, "div0");
        @(negedge clk);
        chk("div0_idle_tx", 32'(tx), 32'd1);
        frame(8'hA3, 1, "div0");
        @(negedge clk);
        chk("div0_end_mesgul", 32'(mesgul), 32'd0);

        // Divider change mid-frame only affects the next frame
        @(posedge clk); #1 baud = 16'd4;
        push(8'h3C, "divchg");
        fork
            begin
                @(negedge clk);
                chk("divchg_idle_tx", 32'(tx), 32'd1);
                frame(8'h3C, 4, "divchg_f4");
                frame(8'hC3, 8, "divchg_f8");
            end
            begin
                push(8'hC3, "divchg2");
                repeat (10) @(posedge clk);
                #1 baud = 16'd8;
            end
        join
        @(negedge clk);
        chk("divchg_end_mesgul", 32'(mesgul), 32'd0);

        // Burst into a depth-4 FIFO behind a frame in flight
        @(posedge clk); #1 baud = 16'd2;
        push(8'h5A, "burst0");
        fork
            begin
                @(negedge clk);
                chk("burst_idle_tx", 32'(tx), 32'd1);
                frame(8'h5A, 2, "burst_5a");
                frame(8'h00, 2, "burst_00");
                frame(8'hFF, 2, "burst_ff");
                frame(8'hA5, 2, "burst_a5");
                frame(8'h3C, 2, "burst_3c");
                frame(8'h81, 2, "burst_81");
            end
            begin
                push(8'h00, "burst1");
                push(8'hFF, "burst2");
                push(8'hA5, "burst3");
                push(8'h3C, "burst4");
                @(negedge clk);
                chk("burst_full_hazir", 32'(hazir), 32'd0);
                chk("burst_full_doluluk", 32'(doluluk), 32'd4);
                push(8'h81, "burst5");
                @(negedge clk);
                chk("burst_after5_doluluk", 32'(doluluk), 32'd4);
            end
        join
        @(negedge clk);
        chk("burst_end_mesgul", 32'(mesgul), 32'd0);
        chk("burst_end_tx", 32'(tx), 32'd1);

        // Push on the stop-bit wrap edge while two bytes are queued
        @(posedge clk); #1 baud = 16'd2;
        push(8'h96, "simul0");
        fork
            begin
                @(negedge clk);
                frame(8'h96, 2, "simul_96");
                frame(8'h12, 2, "simul_12");
                frame(8'h34, 2, "simul_34");
                frame(8'hE7, 2, "simul_e7");
            end
            begin
                push(8'h12, "simul1");
                push(8'h34, "simul2");
                @(negedge clk);
                chk("simul_pre_doluluk", 32'(doluluk), 32'd2);
                repeat (18) @(posedge clk);
                #1;
                push(8'hE7, "simul3");
                @(negedge clk);
                chk("simul_post_doluluk", 32'(doluluk), 32'd2);
            end
        join

`ifdef UART_PARITY_EN
        // 0x07 -> parity 1, 0x03 -> parity 0, 11 bit times each
        @(posedge clk); #1 baud = 16'd2;
        push(8'h07, "par07");
        fork
            begin
                @(negedge clk);
                frame(8'h07, 2, "par07");
                frame(8'h03, 2, "par03");
            end
            push(8'h03, "par03");
        join
        @(negedge clk);
        chk("par_end_mesgul", 32'(mesgul), 32'd0);
`endif

        // Reset during data bit 3 of 0x00 with two bytes queued
        @(posedge clk); #1 baud = 16'd4;
        push(8'h00, "rstm0");
        push(8'h11, "rstm1");
        push(8'h22, "rstm2");
        repeat (15) @(posedge clk);
        #3;
        chk("rstm_bit3_tx", 32'(tx), 32'd0);
        chk("rstm_pre_doluluk", 32'(doluluk), 32'd2);
        rst = 1'b1;
        #1;
        chk("rstm_tx", 32'(tx), 32'd1);
        chk("rstm_doluluk", 32'(doluluk), 32'd0);
        chk("rstm_hazir", 32'(hazir), 32'd1);
        chk("rstm_mesgul", 32'(mesgul), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("rstm_idle_after", 32'(bad), 32'd0);
        chk("rstm_mesgul_after", 32'(mesgul), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
